// File: rtl/vdp_io_pkg.sv
// Shared types and constants for the VDP I/O arbiter.
// Holds the FSM state enum, the VDP port numbers and the pending-access payload.
package vdp_io_pkg;

    localparam int unsigned GAP_W  = 4;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 6;

    localparam logic [PORT_W-1:0] PORT_DATA      = 2'd0;
    localparam logic [PORT_W-1:0] PORT_CTRL      = 2'd1;
    localparam logic [DATA_W-1:0] REG_WRITE_FLAG = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INT_1 = 2'd1,
        ST_INT_2 = 2'd2
    } vdp_state_e;

    typedef struct packed {
        logic              wr;
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } io_acc_t;

endpackage

// File: rtl/vdp_io_arbiter.sv
// Merges CPU port strobes and internal register writes onto one VDP I/O strobe,
// enforcing a minimum idle gap and keeping internal two-byte register writes atomic.
module vdp_io_arbiter
    import vdp_io_pkg::*;
#(
    parameter int unsigned MIN_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [PORT_W-1:0] cpu_port,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cfg_valid,
    input  logic [REG_W-1:0]  cfg_reg,
    input  logic [DATA_W-1:0] cfg_value,
    output logic              cfg_ready,
    output logic              vdp_io_req,
    output logic              vdp_io_wr,
    output logic [PORT_W-1:0] vdp_port,
    output logic [DATA_W-1:0] vdp_data_in,
    output logic              cpu_overrun
);

    vdp_state_e        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    io_acc_t           pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              phase_q, phase_d;
    logic              overrun_q, overrun_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [DATA_W-1:0] data_q, data_d;

    io_acc_t cpu_acc;
    io_acc_t pend_eff;
    logic    pend_eff_vld;
    logic    slot_free;
    logic    cfg_fire;
    logic    cpu_issue;
    logic    byte2_issue;

    assign cpu_acc      = io_acc_t'{wr: cpu_wr, port: cpu_port, data: cpu_data};
    // A strobe arriving this cycle counts as pending so an idle bus issues it next cycle.
    assign pend_eff_vld = pend_vld_q | cpu_req;
    assign pend_eff     = pend_vld_q ? pend_q : cpu_acc;
    // Also blocks back-to-back pulses when MIN_GAP is 0.
    assign slot_free    = (gap_q == '0) && !req_q;

    assign cfg_ready    = !reset && (state_q == ST_IDLE) && slot_free &&
                          !pend_vld_q && !cpu_req && !phase_q;
    assign cfg_fire     = cfg_valid && cfg_ready;
    assign cpu_issue    = (state_q == ST_IDLE) && slot_free && pend_eff_vld;
    assign byte2_issue  = (state_q == ST_INT_2) && slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_fire) state_d = ST_INT_1;
            ST_INT_1: state_d = ST_INT_2;
            ST_INT_2: if (byte2_issue) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d      = 1'b0;
        wr_d       = wr_q;
        port_d     = port_q;
        data_d     = data_q;
        gap_d      = (gap_q == '0) ? gap_q : gap_q - GAP_W'(1);
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        phase_d    = phase_q;
        overrun_d  = overrun_q;
        reg_d      = reg_q;

        if (cpu_issue) begin
            req_d  = 1'b1;
            wr_d   = pend_eff.wr;
            port_d = pend_eff.port;
            data_d = pend_eff.data;
            gap_d  = GAP_W'(MIN_GAP);
            if (pend_eff.port == PORT_CTRL) begin
                phase_d = pend_eff.wr ? !phase_q : 1'b0;
            end
            // A strobe coinciding with a buffered issue refills the buffer.
            if (pend_vld_q) begin
                pend_vld_d = cpu_req;
                pend_d     = cpu_acc;
            end else begin
                pend_vld_d = 1'b0;
            end
        end else if (cpu_req) begin
            if (pend_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_d     = cpu_acc;
            end
        end

        if (cfg_fire) begin
            req_d  = 1'b1;
            wr_d   = 1'b1;
            port_d = PORT_CTRL;
            data_d = cfg_value;
            gap_d  = GAP_W'(MIN_GAP);
            reg_d  = cfg_reg;
        end

        if (byte2_issue) begin
            req_d  = 1'b1;
            wr_d   = 1'b1;
            port_d = PORT_CTRL;
            data_d = REG_WRITE_FLAG | DATA_W'(reg_q);
            gap_d  = GAP_W'(MIN_GAP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            phase_q    <= 1'b0;
            overrun_q  <= 1'b0;
            reg_q      <= '0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            port_q     <= '0;
            data_q     <= '0;
        end else begin
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            phase_q    <= phase_d;
            overrun_q  <= overrun_d;
            reg_q      <= reg_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            port_q     <= port_d;
            data_q     <= data_d;
        end
    end

    assign vdp_io_req  = req_q;
    assign vdp_io_wr   = wr_q;
    assign vdp_port    = port_q;
    assign vdp_data_in = data_q;
    assign cpu_overrun = overrun_q;

endmodule

// File: doc/vdp_io_arbiter.md
VDP_IO_ARBITER -- requirements
Module: vdp_io_arbiter

Interface
REQ-001 Parameter MIN_GAP, default 2, meaning: minimum idle cycles between consecutive vdp_io_req pulses (range 0..15).
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  one-cycle CPU access strobe from the CPU bus interface.
REQ-005 cpu_wr  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_port  input  2  VDP port offset (0 = data $98, 1 = control $99, 2/3 = $9A/$9B).
REQ-007 cpu_data  input  8  CPU write data; qualified by cpu_req.
REQ-008 cfg_valid  input  1  internal register-write request valid.
REQ-009 cfg_reg  input  6  target VDP register number.
REQ-010 cfg_value  input  8  value for target register.
REQ-011 cfg_ready  output  1  internal request accepted when cfg_valid & cfg_ready.
REQ-012 vdp_io_req  output  1  one-cycle access strobe to VDP core.
REQ-013 vdp_io_wr  output  1  write qualifier for vdp_io_req.
REQ-014 vdp_port  output  2  port offset for vdp_io_req.
REQ-015 vdp_data_in  output  8  write data for vdp_io_req.
REQ-016 cpu_overrun  output  1  sticky: a CPU strobe was dropped.

Function
REQ-017 A cpu_req SHALL be captured into a one-entry pending buffer (wr, port, data) in the cycle it is high.
REQ-018 FSM states SHALL be IDLE, INT_1, INT_2; a gap counter SHALL be loaded with MIN_GAP on every vdp_io_req pulse and decrement to 0.
REQ-019 Issue rule: after a pulse at cycle T, the next pulse SHALL occur no earlier than T+1+MIN_GAP.
REQ-020 In IDLE with gap 0 and pending full, the pending access SHALL be issued (vdp_io_req=1, its wr/port/data) and pending cleared; minimum CPU latency is cpu_req at N -> vdp_io_req at N+1.
REQ-021 cfg_ready SHALL be high only in IDLE with gap 0, pending empty, cpu_req low, and cpu_phase 0 (CPU-first priority).
REQ-022 On handshake at N, cfg_reg/cfg_value SHALL be latched and FSM -> INT_1; byte 1 (vdp_port=1, wr=1, data=cfg_value) SHALL issue at N+1, FSM -> INT_2.
REQ-023 INT_2 SHALL issue byte 2 (port 1, wr=1, data=8'h80|cfg_reg) when gap reaches 0, then -> IDLE; pending CPU accesses SHALL wait until after byte 2 (pair is atomic).
REQ-024 cpu_phase SHALL toggle on each issued CPU write to port 1 and clear on each issued CPU read of port 1; internal pairs SHALL not alter it.
REQ-025 cpu_req while pending is full and not being issued that cycle SHALL be dropped and set cpu_overrun=1 until reset; cpu_req in the same cycle the pending entry issues SHALL be captured.
REQ-026 vdp_io_req SHALL never be high two consecutive cycles; outputs other than vdp_io_req are don't-care when it is low but SHALL hold last values.

Reset
REQ-027 Reset SHALL force: state IDLE, gap 0, pending empty, cpu_phase 0, cpu_overrun 0, cfg_ready 0, vdp_io_req 0, vdp_io_wr 0, vdp_port 0, vdp_data_in 0.
REQ-028 Reset during INT_1/INT_2 SHALL abandon the pair with no further pulses; recovery of VDP port-1 latch state is the requester's duty.

Structure
REQ-029 Package vdp_io_pkg SHALL hold the FSM state enum, PORT_DATA=0, PORT_CTRL=1, and REG_WRITE_FLAG=8'h80.
REQ-030 Single module, no sub-modules; expected 150-250 lines of RTL.

Verification (MIN_GAP=2)
REQ-031 Idle, cpu_req at N (wr=1, port 0, data 8'h5A) -> vdp_io_req at N+1, wr=1, port 0, data 8'h5A.
REQ-032 cfg handshake at N (reg 7, value 8'h14) -> pulses at N+1 (port 1, 8'h14) and N+4 (port 1, 8'h87).
REQ-033 Handshake at N, cpu_req at N+2 (read, port 1) -> pulses N+1, N+4 (8'h87), then CPU read at N+7; cpu_phase stays 0.
REQ-034 CPU write port 1 (phase=1) with cfg_valid held -> cfg_ready low until a second CPU port-1 write or a port-1 read issues.
REQ-035 During INT_2 wait, cpu_req at N then N+1 -> second dropped, cpu_overrun=1; only first issued.
REQ-036 Reset asserted the cycle after byte 1 -> all outputs 0 asynchronously, no byte 2 after release.
